multi_cycle_cpu: RTL

- Parametrised multi-cycle MIPS-subset core; next generation of the team's single-cycle CPU.
- One instruction is sequenced through an FSM: FETCH, DECODE, EXEC, WB.
- Instruction fetch goes over a req/valid handshake to external instruction memory, so wait states are tolerated.
- Adds branches, variable shifts, halt, a retire strobe and a debug register-read port.

---
 rtl/multi_cycle_cpu_if.sv | 12 +
 rtl/multi_cycle_cpu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_cpu_if.sv
// Instruction-fetch handshake between the core (master) and instruction memory (slave).
interface multi_cycle_cpu_if #(
   parameter int unsigned PC_W = 32
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_valid;

   modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
   modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/WB sequencing with a req/valid fetch port.
// Define MULTI_CYCLE_CPU_PERF_EN to instantiate the cycle and retire counters.
module multi_cycle_cpu #(
   parameter int unsigned    DATA_W   = 32,
   parameter int unsigned    NUM_REGS = 32,
   parameter int unsigned    PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   multi_cycle_cpu_if.master    imem,
   output logic                 retire_o,
   output logic                 halted_o,
   input  logic [4:0]           dbg_raddr_i,
   output logic [DATA_W-1:0]    dbg_rdata_o,
   output logic [31:0]          cyc_cnt_o,
   output logic [31:0]          ret_cnt_o
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_HALT  = 6'h3f;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_SLT  = 6'h2a;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic              taken_q, taken_d;
   logic              retire_q, retire_d;
   logic              halted_q, halted_d;
   logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

   logic [5:0]        opcode;
   logic [4:0]        rs, rt, rd, shamt;
   logic [5:0]        funct;
   logic [31:0]       ext32;
   logic signed [31:0] br_off32;
   logic [PC_W-1:0]   pc_plus4;
   logic [PC_W-1:0]   br_tgt;

   logic [DATA_W-1:0] rs_val, rt_val;
   logic [4:0]        sh_amt;
   logic              sh_big;
   logic [DATA_W-1:0] alu_res;
   logic              wr_en;
   logic [4:0]        wr_idx;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign shamt    = ir_q[10:6];
   assign funct    = ir_q[5:0];
   assign ext32    = {{16{ir_q[15]}}, ir_q[15:0]};
   assign br_off32 = $signed({ext32[29:0], 2'b00});
   assign pc_plus4 = pc_q + PC_W'(4);
   assign br_tgt   = pc_plus4 + PC_W'(br_off32);

   // Register read ports; index 0 and indices beyond NUM_REGS-1 read as zero.
   always_comb begin
      rs_val      = '0;
      rt_val      = '0;
      dbg_rdata_o = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (rs == 5'(i))          rs_val      = regs_q[i];
         if (rt == 5'(i))          rt_val      = regs_q[i];
         if (dbg_raddr_i == 5'(i)) dbg_rdata_o = regs_q[i];
      end
   end

   // ALU result and write-back decode, both driven from the held IR.
   always_comb begin
      sh_amt  = (funct == F_SLLV || funct == F_SRLV) ? a_q[4:0] : shamt;
      sh_big  = (32'(sh_amt) >= DATA_W);
      alu_res = '0;
      wr_en   = 1'b0;
      wr_idx  = (opcode == OP_RTYPE) ? rd : rt;
      case (opcode)
         OP_RTYPE: begin
            wr_en = 1'b1;
            case (funct)
               F_ADD:         alu_res = a_q + b_q;
               F_SUB:         alu_res = a_q - b_q;
               F_AND:         alu_res = a_q & b_q;
               F_OR:          alu_res = a_q | b_q;
               F_SLT:         alu_res = DATA_W'($signed(a_q) < $signed(b_q));
               F_SLL, F_SLLV: alu_res = sh_big ? '0 : (b_q << sh_amt);
               F_SRL, F_SRLV: alu_res = sh_big ? '0 : (b_q >> sh_amt);
               default:       wr_en   = 1'b0;
            endcase
         end
         OP_ADDI: begin
            wr_en   = 1'b1;
            alu_res = a_q + imm_q;
         end
         OP_LUI: begin
            wr_en   = 1'b1;
            alu_res = DATA_W'({ir_q[15:0], 16'h0000});
         end
         default: ;
      endcase
   end

   // Sequencer next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      alu_d   = alu_q;
      taken_d = taken_q;
      case (state_q)
         S_FETCH: begin
            if (imem.imem_valid) begin
               ir_d    = imem.imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = rs_val;
            b_d     = rt_val;
            imm_d   = DATA_W'(ext32);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            alu_d   = alu_res;
            taken_d = (opcode == OP_BEQ && a_q == b_q) || (opcode == OP_BNE && a_q != b_q);
            state_d = S_WB;
         end
         S_WB: begin
            pc_d    = taken_q ? br_tgt : pc_plus4;
            state_d = (opcode == OP_HALT) ? S_HALT : S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
      retire_d = (state_d == S_WB);
      halted_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         alu_q    <= '0;
         taken_q  <= 1'b0;
         retire_q <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         alu_q    <= alu_d;
         taken_q  <= taken_d;
         retire_q <= retire_d;
         halted_q <= halted_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (state_q == S_WB && wr_en) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_idx == 5'(i)) regs_q[i] <= alu_q;
         end
      end
   end

   // Request drops in the same cycle reset is asserted, not at the next edge.
   assign imem.imem_req  = (state_q == S_FETCH) && !rst_i;
   assign imem.imem_addr = pc_q;
   assign retire_o       = retire_q;
   assign halted_o       = halted_q;

`ifdef MULTI_CYCLE_CPU_PERF_EN
   logic [31:0] cyc_cnt_q, ret_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_cnt_q <= '0;
         ret_cnt_q <= '0;
      end else if (!halted_q) begin
         cyc_cnt_q <= cyc_cnt_q + 32'd1;
         if (retire_q) ret_cnt_q <= ret_cnt_q + 32'd1;
      end
   end

   assign cyc_cnt_o = cyc_cnt_q;
   assign ret_cnt_o = ret_cnt_q;
`else
   assign cyc_cnt_o = '0;
   assign ret_cnt_o = '0;
`endif

endmodule
